// File: rtl/duck_game_pkg.sv
// duck_game_pkg: constants and types shared by the duck game blocks.
//   - resolver FSM state encoding (the FLASH state exists only when
//     DUCK_SHOT_FLASH_EN is defined)
//   - default duck sprite size and the screen dimensions used by the drawer
//   - in_span(): half-open interval membership test used by the hit test
package duck_game_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int DUCK_W_DEFAULT = 46;
  localparam int DUCK_H_DEFAULT = 40;

`ifdef DUCK_SHOT_FLASH_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMING  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_FLASH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMING  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_RELEASE = 3'd4
  } state_t;
`endif

  // True when lo <= pt < lo + len, all operands 12-bit signed.
  function automatic logic in_span(input logic signed [11:0] lo,
                                   input logic signed [11:0] pt,
                                   input logic signed [11:0] len);
    logic signed [11:0] hi;
    hi = lo + len;
    return (pt >= lo) && (pt < hi);
  endfunction

endpackage

// File: rtl/duck_shot_resolver_if.sv
// duck_shot_if: bundle of the resolver's game-side signals.
//   inputs to resolver : trigger, aim_x[9:0], aim_y[9:0], duck_x[10:0] (signed),
//                        duck_y[9:0] (signed), vcount[9:0]
//   outputs of resolver: collision, flash, score[7:0], ammo[1:0], busy
//   modport slave  : the resolver side
//   modport master : the side driving trigger/positions and consuming results
interface duck_shot_if;
  logic        trigger;
  logic [9:0]  aim_x;
  logic [9:0]  aim_y;
  logic [10:0] duck_x;
  logic [9:0]  duck_y;
  logic [9:0]  vcount;
  logic        collision;
  logic        flash;
  logic [7:0]  score;
  logic [1:0]  ammo;
  logic        busy;

  modport slave (
    input  trigger, aim_x, aim_y, duck_x, duck_y, vcount,
    output collision, flash, score, ammo, busy
  );

  modport master (
    output trigger, aim_x, aim_y, duck_x, duck_y, vcount,
    input  collision, flash, score, ammo, busy
  );
endinterface

// File: rtl/duck_shot_resolver_trigger_debouncer.sv
// trigger_debouncer: 2-flop synchronizer plus debounce counter for the raw
// trigger button.
//   clk, reset (async active-low)
//   trigger     : raw button level
//   arm         : high while the resolver is in its ARMING state; the counter
//                 runs only then and clears otherwise
//   trig_stable : synchronized trigger level, held low after reset until the
//                 button has been seen released once (a button held through
//                 reset never counts as a new press)
//   trig_rise   : one-cycle strobe when the level has been held for
//                 DEBOUNCE_CYCLES counts while armed
module trigger_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic arm,
  output logic trig_stable,
  output logic trig_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic [1:0]    fill_r;     // marks when sync_r holds real samples
  logic          released_r;
  logic [CW-1:0] cnt_r;

  assign trig_stable = sync_r[1] & released_r;
  assign trig_rise   = arm & trig_stable & (cnt_r == CNT_LAST);

  // Synchronizer, fill tracker and released-once flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r     <= 2'b00;
      fill_r     <= 2'b00;
      released_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], trigger};
      fill_r <= {fill_r[0], 1'b1};
      if (fill_r[1] && !sync_r[1]) begin
        released_r <= 1'b1;
      end else begin
        released_r <= released_r;
      end
    end
  end

  // Debounce counter: counts while armed and held, saturating at the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (arm && trig_stable) begin
      if (cnt_r != CNT_LAST) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= '0;
    end
  end

endmodule

// File: rtl/duck_shot_resolver.sv
// duck_shot_resolver: debounces the trigger, hit-tests the crosshair against
// the duck's live bounding box, and keeps score and ammo.
//   clk   : pixel clock
//   reset : asynchronous, active-low
//   bus   : duck_shot_if.slave (trigger, aim, duck position, vcount in;
//           collision, flash, score, ammo, busy out)
// Optional feature: DUCK_SHOT_FLASH_EN adds the FLASH state that holds
// flash high until the next frame start; without it flash is constant 0
// and FIRE goes straight to RELEASE.
module duck_shot_resolver
  import duck_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DUCK_W          = DUCK_W_DEFAULT,
  parameter int DUCK_H          = DUCK_H_DEFAULT,
  parameter int AMMO_MAX        = 3,
  parameter int RELOAD_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  duck_shot_if.slave  bus
);

  localparam logic signed [11:0] DUCK_W_S   = 12'(DUCK_W);
  localparam logic signed [11:0] DUCK_H_S   = 12'(DUCK_H);
  localparam logic [1:0]         AMMO_FULL  = 2'(AMMO_MAX);
  localparam int                 RW         = (RELOAD_FRAMES > 1) ? $clog2(RELOAD_FRAMES) : 1;
  localparam logic [RW-1:0]      RELOAD_LAST = RW'(RELOAD_FRAMES - 1);

  state_t  state_r, state_nx;
  logic    trig_stable_s, trig_rise_s;
  logic    frame_start_s, fire_s, hit_s;
  logic [9:0]    vcount_prev_r;
  logic [RW-1:0] reload_cnt_r;
  logic          collision_r, busy_r;
  logic [7:0]    score_r;
  logic [1:0]    ammo_r;
  logic signed [11:0] aim_x_e, aim_y_e, duck_x_e, duck_y_e;

  trigger_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .trigger    (bus.trigger),
    .arm        (state_r == ST_ARMING),
    .trig_stable(trig_stable_s),
    .trig_rise  (trig_rise_s)
  );

  assign frame_start_s = (bus.vcount == 10'd0) && (vcount_prev_r != 10'd0);
  assign fire_s        = (state_r == ST_FIRE);

  // Aim is unsigned, so it widens with zeros; duck edges are signed.
  assign aim_x_e  = {2'b00, bus.aim_x};
  assign aim_y_e  = {2'b00, bus.aim_y};
  assign duck_x_e = {bus.duck_x[10], bus.duck_x};
  assign duck_y_e = {{2{bus.duck_y[9]}}, bus.duck_y};
  assign hit_s    = in_span(duck_x_e, aim_x_e, DUCK_W_S) &&
                    in_span(duck_y_e, aim_y_e, DUCK_H_S);

  // Shot FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Shot FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_stable_s) begin
          state_nx = ST_ARMING;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (!trig_stable_s) begin
          state_nx = ST_IDLE;
        end else if (trig_rise_s) begin
          // An empty magazine dry-fires: no hit test, no ammo change.
          if (ammo_r != 2'd0) begin
            state_nx = ST_FIRE;
          end else begin
            state_nx = ST_RELEASE;
          end
        end else begin
          state_nx = ST_ARMING;
        end
      end
      ST_FIRE: begin
`ifdef DUCK_SHOT_FLASH_EN
        state_nx = ST_FLASH;
`else
        state_nx = ST_RELEASE;
`endif
      end
`ifdef DUCK_SHOT_FLASH_EN
      ST_FLASH: begin
        if (frame_start_s) begin
          state_nx = ST_RELEASE;
        end else begin
          state_nx = ST_FLASH;
        end
      end
`endif
      ST_RELEASE: begin
        // Holding the trigger never re-fires; it must be let go first.
        if (!trig_stable_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RELEASE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Frame edge detector history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcount_prev_r <= 10'd0;
    end else begin
      vcount_prev_r <= bus.vcount;
    end
  end

  // Collision pulse, busy flag, score and ammo (including frame-based reload).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_r  <= 1'b0;
      busy_r       <= 1'b0;
      score_r      <= 8'd0;
      ammo_r       <= AMMO_FULL;
      reload_cnt_r <= '0;
    end else begin
      collision_r <= fire_s && hit_s;
      busy_r      <= (state_nx != ST_IDLE);
      if (fire_s) begin
        if (hit_s) begin
          score_r <= (score_r == 8'hFF) ? 8'hFF : (score_r + 8'd1);
          ammo_r  <= AMMO_FULL;
        end else begin
          score_r <= score_r;
          ammo_r  <= ammo_r - 2'd1;
        end
      end else if ((ammo_r == 2'd0) && frame_start_s && (reload_cnt_r == RELOAD_LAST)) begin
        ammo_r <= AMMO_FULL;
      end else begin
        ammo_r <= ammo_r;
      end
      // The reload counter only runs while the magazine is empty.
      if (ammo_r != 2'd0) begin
        reload_cnt_r <= '0;
      end else if (frame_start_s) begin
        if (reload_cnt_r == RELOAD_LAST) begin
          reload_cnt_r <= '0;
        end else begin
          reload_cnt_r <= reload_cnt_r + RW'(1);
        end
      end else begin
        reload_cnt_r <= reload_cnt_r;
      end
    end
  end

`ifdef DUCK_SHOT_FLASH_EN
  logic flash_r;

  // Muzzle flash follows the FLASH state, rising with the collision pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_r <= 1'b0;
    end else begin
      flash_r <= (state_nx == ST_FLASH);
    end
  end

  assign bus.flash = flash_r;
`else
  assign bus.flash = 1'b0;
`endif

  assign bus.collision = collision_r;
  assign bus.busy      = busy_r;
  assign bus.score     = score_r;
  assign bus.ammo      = ammo_r;

endmodule

// File: tb/tb_duck_shot_resolver.sv
// Testbench for duck_shot_resolver (DEBOUNCE_CYCLES=4, RELOAD_FRAMES=2).
// Reference model tracks score, ammo and the empty-frame count as integers;
// hits are computed from the bounding-box rule with plain integer arithmetic.
module tb_duck_shot_resolver;

  localparam int DEB    = 4;
  localparam int RELOAD = 2;
  localparam int AMAX   = 3;
`ifdef DUCK_SHOT_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  duck_shot_if bus ();

  duck_shot_resolver #(
    .DEBOUNCE_CYCLES(DEB),
    .RELOAD_FRAMES  (RELOAD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int score_m = 0;
  int ammo_m  = AMAX;
  int fc_m    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic model_frame();
    if (ammo_m == 0) begin
      fc_m++;
      if (fc_m == RELOAD) begin
        ammo_m = AMAX;
        fc_m   = 0;
      end
    end else begin
      fc_m = 0;
    end
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    bus.vcount = 10'd0;
    @(negedge clk);
    bus.vcount = 10'd1;
    model_frame();
  endtask

  // One trigger press of 'hold' cycles, then release and one frame start.
  task automatic do_shot(input string name, input int hold, input int dx, input int dy,
                         input int ax, input int ay);
    int coll_cnt;
    bit real_fire, hit;
    @(negedge clk);
    bus.duck_x = 11'(dx);
    bus.duck_y = 10'(dy);
    bus.aim_x  = 10'(ax);
    bus.aim_y  = 10'(ay);
    real_fire = (hold >= 8) && (ammo_m != 0);
    hit = real_fire && (ax >= dx) && (ax < dx + 46) && (ay >= dy) && (ay < dy + 40);
    if (real_fire) begin
      if (hit) begin
        score_m = (score_m < 255) ? score_m + 1 : 255;
        ammo_m  = AMAX;
      end else begin
        ammo_m = ammo_m - 1;
      end
    end
    if (ammo_m != 0) fc_m = 0;
    coll_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      bus.trigger = (i < hold);
      @(posedge clk);
      #1;
      if (bus.collision === 1'b1) begin
        coll_cnt++;
        n_vec++;
        if (bus.score !== 8'(score_m) || bus.ammo !== 2'(ammo_m) || bus.flash !== FLASH_ON) begin
          n_err++;
          $display("FAIL %s pulse-cycle: score %0d ammo %0d flash %0b, required score %0d ammo %0d flash %0b",
                   name, bus.score, bus.ammo, bus.flash, score_m, ammo_m, FLASH_ON);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (coll_cnt !== (hit ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s collision: %0d pulse cycles, required %0d", name, coll_cnt, hit ? 1 : 0);
    end
    n_vec++;
    if (bus.score !== 8'(score_m) || bus.ammo !== 2'(ammo_m)) begin
      n_err++;
      $display("FAIL %s score/ammo: %0d/%0d, required %0d/%0d", name, bus.score, bus.ammo, score_m, ammo_m);
    end
    n_vec++;
    if (bus.flash !== (real_fire && FLASH_ON) || bus.busy !== (real_fire && FLASH_ON)) begin
      n_err++;
      $display("FAIL %s flash/busy before frame: %0b/%0b, required %0b/%0b", name, bus.flash, bus.busy,
               real_fire && FLASH_ON, real_fire && FLASH_ON);
    end
    frame_pulse();
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.flash !== 1'b0 || bus.busy !== 1'b0 || bus.ammo !== 2'(ammo_m)) begin
      n_err++;
      $display("FAIL %s after frame: flash %0b busy %0b ammo %0d, required 0 0 %0d", name, bus.flash,
               bus.busy, bus.ammo, ammo_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.trigger = 1'b0;
    bus.aim_x = 10'd0;
    bus.aim_y = 10'd0;
    bus.duck_x = 11'd0;
    bus.duck_y = 10'd0;
    bus.vcount = 10'd1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.collision !== 1'b0 || bus.flash !== 1'b0 || bus.busy !== 1'b0 ||
        bus.score !== 8'd0 || bus.ammo !== 2'd3) begin
      n_err++;
      $display("FAIL reset_values: coll %0b flash %0b busy %0b score %0d ammo %0d, required 0 0 0 0 3",
               bus.collision, bus.flash, bus.busy, bus.score, bus.ammo);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.ammo !== 2'd3 || bus.score !== 8'd0) begin
      n_err++;
      $display("FAIL after_reset: busy %0b ammo %0d score %0d, required 0 3 0", bus.busy, bus.ammo, bus.score);
    end
  endtask

  task automatic test_hit_miss_edges();
    do_shot("hit", 10, 100, 50, 120, 60);
    do_shot("miss_right", 10, 100, 50, 146, 60);
    do_shot("corner_hit", 10, 100, 50, 145, 89);
    do_shot("neg_x_hit", 10, -20, 0, 10, 5);
    do_shot("neg_x_miss", 10, -20, 0, 26, 5);
    do_shot("below_miss", 10, 100, 50, 120, 90);
  endtask

  task automatic test_bounce();
    int coll_cnt = 0;
    bit busy_seen = 1'b0;
    @(negedge clk);
    bus.duck_x = 11'd100;
    bus.duck_y = 10'd50;
    bus.aim_x  = 10'd120;
    bus.aim_y  = 10'd60;
    for (int i = 0; i < 25; i++) begin
      bus.trigger = (i < 3) || (i >= 6 && i < 9);
      @(posedge clk);
      #1;
      if (bus.collision === 1'b1) coll_cnt++;
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (coll_cnt !== 0 || bus.ammo !== 2'(ammo_m) || bus.score !== 8'(score_m)) begin
      n_err++;
      $display("FAIL bounce: pulses %0d ammo %0d score %0d, required 0 %0d %0d", coll_cnt, bus.ammo,
               bus.score, ammo_m, score_m);
    end
    n_vec++;
    if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_busy: seen %0b final %0b, required 1 0", busy_seen, bus.busy);
    end
  endtask

  task automatic test_empty();
    int guard = 0;
    while (ammo_m != 0 && guard < 5) begin
      do_shot("empty_miss", 10, 100, 50, 300, 300);
      guard++;
    end
    n_vec++;
    if (bus.ammo !== 2'd0) begin
      n_err++;
      $display("FAIL empty_ammo: %0d, required 0", bus.ammo);
    end
    do_shot("dry_fire", 10, 100, 50, 120, 60);
    n_vec++;
    if (bus.ammo !== 2'd3) begin
      n_err++;
      $display("FAIL reload: ammo %0d, required 3", bus.ammo);
    end
  endtask

  task automatic test_reset_mid_shot();
    bit seen = 1'b0;
    int coll_cnt = 0;
    bit busy_bad = 1'b0;
    @(negedge clk);
    bus.duck_x = 11'd100;
    bus.duck_y = 10'd50;
    bus.aim_x  = 10'd120;
    bus.aim_y  = 10'd60;
    bus.trigger = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.collision === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_mid_fire: collision 0 within 20 cycles, required 1");
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    score_m = 0;
    ammo_m  = AMAX;
    fc_m    = 0;
    n_vec++;
    if (bus.flash !== 1'b0 || bus.score !== 8'd0 || bus.ammo !== 2'd3 || bus.busy !== 1'b0 ||
        bus.collision !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: flash %0b score %0d ammo %0d busy %0b coll %0b, required 0 0 3 0 0",
               bus.flash, bus.score, bus.ammo, bus.busy, bus.collision);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.collision === 1'b1) coll_cnt++;
      if (bus.busy !== 1'b0) busy_bad = 1'b1;
    end
    n_vec++;
    if (coll_cnt !== 0 || busy_bad !== 1'b0) begin
      n_err++;
      $display("FAIL held_through_reset: pulses %0d busy_seen %0b, required 0 0", coll_cnt, busy_bad);
    end
    @(negedge clk);
    bus.trigger = 1'b0;
    repeat (5) @(negedge clk);
    do_shot("after_reset_hit", 10, 100, 50, 120, 60);
  endtask

  task automatic test_random();
    int dx, dy, ax, ay, hold;
    for (int n = 0; n < 16; n++) begin
      dx = int'($urandom_range(760)) - 60;
      dy = int'($urandom_range(520)) - 50;
      ax = dx + int'($urandom_range(66)) - 10;
      ay = dy + int'($urandom_range(60)) - 10;
      if (ax < 0) ax = 0;
      if (ax > 1023) ax = 1023;
      if (ay < 0) ay = 0;
      if (ay > 1023) ay = 1023;
      hold = ($urandom_range(3) == 0) ? 3 : 10;
      do_shot("random", hold, dx, dy, ax, ay);
    end
  endtask

  initial begin
    test_reset();
    test_hit_miss_edges();
    test_bounce();
    test_empty();
    test_reset_mid_shot();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
